// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one registered unsigned multiplier among N_REQ requesters.
// Two-cycle grant-to-result latency: operand capture, then product capture.
module mult_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*W-1:0]         req_a,
   input  logic [N_REQ*W-1:0]         req_b,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       rsp_valid,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [2*W-1:0]             rsp_result,
   input  logic                       rsp_ready,
   output logic                       busy
);

   localparam int ID_W = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

   state_t          state;
   logic [ID_W-1:0] last;
   logic [ID_W-1:0] tag;
   logic [ID_W-1:0] winner;
   logic            grant_any;
   logic [W-1:0]    sel_a, sel_b;
   logic [W-1:0]    op_a, op_b;
   logic [2*W-1:0]  product;
   logic [2*W-1:0]  result;

   // Grant window: IDLE, or OUT while the current result is being released.
   // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      winner    = '0;
      req_ready = '0;
      if (reset && (state == IDLE || (state == OUT && rsp_ready))) begin
         for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!grant_any && req_valid[ID_W'(idx)]) begin
               grant_any = 1'b1;
               winner    = ID_W'(idx);
            end
         end
         if (grant_any) req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            sel_a = req_a[i*W +: W];
            sel_b = req_b[i*W +: W];
         end
      end
   end

   // The single shared multiplier; operands zero-extended so the product keeps all 2*W bits.
   assign product = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};

   // NOTE: operand registers carry no reset; they are only observed through the result register, which is reset.
   always_ff @(posedge clk) begin
      if (grant_any) begin
         op_a <= sel_a;
         op_b <= sel_b;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         last      <= ID_W'(N_REQ - 1);
         tag       <= '0;
         result    <= '0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  state <= MUL;
                  busy  <= 1'b1;
               end
            end
            MUL: begin
               result    <= product;
               state     <= OUT;
               rsp_valid <= 1'b1;
            end
            OUT: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (grant_any) begin
                     state <= MUL;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
         if (grant_any) begin
            last <= winner;
            tag  <= winner;
         end
      end
   end

   assign rsp_id     = tag;
   assign rsp_result = result;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: a per-cycle vector table plus hand-built
// sequences for idle stability, maximum operands and reset during MUL.
module tb_mult_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      logic         rst;
      logic [N-1:0] valid;
      logic         rr;
      logic [N-1:0] ready;
      logic         rv;
      logic [1:0]   id;
      logic [63:0]  res;
      logic         busy;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [2*W-1:0] rsp_result;
   logic           rsp_ready;
   logic           busy;

   logic [W-1:0]   op_a [N];
   logic [W-1:0]   op_b [N];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
      end
   end

   mult_arbiter #(.N_REQ(N), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
   );

   function automatic vec_t v(input logic rst, input logic [N-1:0] valid, input logic rr,
                              input logic [N-1:0] ready, input logic rv, input logic [1:0] id,
                              input logic [63:0] res, input logic bsy);
      vec_t t;
      t.rst = rst; t.valid = valid; t.rr = rr; t.ready = ready;
      t.rv = rv; t.id = id; t.res = res; t.busy = bsy;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Drive one cycle's inputs at the falling edge and compare outputs just after.
   task automatic step(input vec_t t, input string tag);
      @(negedge clk);
      reset     = t.rst;
      req_valid = t.valid;
      rsp_ready = t.rr;
      #1;
      check({tag, " req_ready"},  64'(req_ready),  64'(t.ready));
      check({tag, " rsp_valid"},  64'(rsp_valid),  64'(t.rv));
      check({tag, " rsp_id"},     64'(rsp_id),     64'(t.id));
      check({tag, " rsp_result"}, rsp_result,      t.res);
      check({tag, " busy"},       64'(busy),       64'(t.busy));
   endtask

   localparam logic [63:0] MAXP = 64'hFFFF_FFFE_0000_0001;

   initial begin
      vec_t tbl[$];

      op_a[0] = 32'd10; op_b[0] = 32'd2;   // 20
      op_a[1] = 32'd20; op_b[1] = 32'd4;   // 80
      op_a[2] = 32'd3;  op_b[2] = 32'd5;   // 15
      op_a[3] = 32'd7;  op_b[3] = 32'd9;   // 63

      //                  rst valid   rr   ready   rv id  res    busy
      tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 0, 0, 64'd0,  0)); // reset state
      tbl.push_back(v(0, 4'b1111, 1, 4'b0000, 0, 0, 64'd0,  0)); // no grant under reset
      tbl.push_back(v(1, 4'b0100, 1, 4'b0100, 0, 0, 64'd0,  0)); // first cycle out of reset: req 2
      tbl.push_back(v(1, 4'b0000, 1, 4'b0000, 0, 2, 64'd0,  1)); // MUL
      tbl.push_back(v(1, 4'b0000, 1, 4'b0000, 1, 2, 64'd15, 1)); // OUT: 3*5
      tbl.push_back(v(1, 4'b0000, 1, 4'b0000, 0, 2, 64'd15, 0)); // back to IDLE
      tbl.push_back(v(0, 4'b1111, 1, 4'b0000, 0, 2, 64'd15, 0)); // reset again
      tbl.push_back(v(1, 4'b1111, 1, 4'b0001, 0, 0, 64'd0,  0)); // round-robin: 0
      tbl.push_back(v(1, 4'b1111, 1, 4'b0000, 0, 0, 64'd0,  1));
      tbl.push_back(v(1, 4'b1111, 1, 4'b0010, 1, 0, 64'd20, 1)); // 1, released with result of 0
      tbl.push_back(v(1, 4'b1111, 1, 4'b0000, 0, 1, 64'd20, 1));
      tbl.push_back(v(1, 4'b1111, 1, 4'b0100, 1, 1, 64'd80, 1)); // 2
      tbl.push_back(v(1, 4'b1111, 1, 4'b0000, 0, 2, 64'd80, 1));
      tbl.push_back(v(1, 4'b1111, 1, 4'b1000, 1, 2, 64'd15, 1)); // 3
      tbl.push_back(v(1, 4'b1111, 1, 4'b0000, 0, 3, 64'd15, 1));
      tbl.push_back(v(1, 4'b1111, 1, 4'b0001, 1, 3, 64'd63, 1)); // wraps to 0
      tbl.push_back(v(1, 4'b0010, 1, 4'b0000, 0, 0, 64'd63, 1));
      for (int i = 0; i < 5; i++)                                 // backpressure, req 1 pending
         tbl.push_back(v(1, 4'b0010, 0, 4'b0000, 1, 0, 64'd20, 1));
      tbl.push_back(v(1, 4'b0010, 1, 4'b0010, 1, 0, 64'd20, 1)); // release + grant same cycle
      tbl.push_back(v(1, 4'b0000, 1, 4'b0000, 0, 1, 64'd20, 1));
      tbl.push_back(v(1, 4'b0000, 1, 4'b0000, 1, 1, 64'd80, 1));

      reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

      // Idle for 20 cycles; last winner was 1, so the next grant must go to 2.
      for (int i = 0; i < 20; i++) step(v(1, 4'b0000, 1, 4'b0000, 0, 1, 64'd80, 0), $sformatf("idle%0d", i));

      op_a[3] = 32'hFFFF_FFFF; op_b[3] = 32'hFFFF_FFFF;
      step(v(1, 4'b1111, 1, 4'b0100, 0, 1, 64'd80, 0), "rr_after_idle");
      step(v(1, 4'b1111, 1, 4'b0000, 0, 2, 64'd80, 1), "max_mul0");
      step(v(1, 4'b1111, 1, 4'b1000, 1, 2, 64'd15, 1), "max_out0");
      step(v(1, 4'b1111, 1, 4'b0000, 0, 3, 64'd15, 1), "max_mul");
      step(v(1, 4'b1111, 1, 4'b0001, 1, 3, MAXP,   1), "max_out");

      // Requester 0 is now in MUL; a one-cycle reset must discard it.
      step(v(0, 4'b0000, 1, 4'b0000, 0, 0, MAXP,   1), "rst_in_mul");
      step(v(1, 4'b0000, 1, 4'b0000, 0, 0, 64'd0,  0), "after_rst0");
      step(v(1, 4'b0000, 1, 4'b0000, 0, 0, 64'd0,  0), "after_rst1");
      step(v(1, 4'b0000, 1, 4'b0000, 0, 0, 64'd0,  0), "after_rst2");
      step(v(1, 4'b1111, 1, 4'b0001, 0, 0, 64'd0,  0), "rst_ptr");
      step(v(1, 4'b0000, 1, 4'b0000, 0, 0, 64'd0,  1), "rst_ptr_mul");
      step(v(1, 4'b0000, 1, 4'b0000, 1, 0, 64'd20, 1), "rst_ptr_out");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the multiplier; legal range 2..8.
REQ-002 Parameter W, default 32: operand width; the product is 2*W bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 req_valid  input  N_REQ  bit i: requester i presents an operand pair.
REQ-006 req_a  input  N_REQ*W  flattened operand A; requester i occupies bits [i*W +: W].
REQ-007 req_b  input  N_REQ*W  flattened operand B; same packing as req_a.
REQ-008 req_ready  output  N_REQ  one-hot grant; bit i high means requester i's pair is accepted this cycle.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  clog2(N_REQ)  index of the requester that owns rsp_result.
REQ-011 rsp_result  output  2*W  unsigned product A*B.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Datapath: one shared instance of the team's registered multiplier, reached through input operand registers, the combinational tree multiplier and a 2*W output register; the block SHALL contain no second multiplier.
REQ-015 Handshake: a request transfers on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 Requester obligations: once req_valid[i] is raised, requester i holds it and keeps its operands stable until accepted; the block is not required to tolerate withdrawal.
REQ-017 FSM states and transitions:
- IDLE -> MUL on a grant.
- MUL -> OUT unconditionally after 1 cycle.
- OUT -> IDLE on rsp_ready with no new grant.
- OUT -> MUL on rsp_ready with a new grant in the same cycle.
- OUT holds while rsp_ready is low.
REQ-018 Grant timing: req_ready is asserted only in IDLE, or in OUT on a cycle where rsp_ready is high; it is combinational from req_valid, rsp_ready and the state; at most one bit is high.
REQ-019 Capture: on the grant edge the winning operands load into the multiplier input registers and the winner index loads into a tag register.
REQ-020 Compute: in MUL the product is computed and captured into the output register at the end of the cycle.
REQ-021 Latency: for a grant in cycle T, rsp_valid is high from cycle T+2; the peak rate is one operation every 2 cycles.
REQ-022 Result hold: while rsp_valid is high and rsp_ready is low, rsp_result and rsp_id stay constant and no new grant is issued.
REQ-023 rsp_valid is high exactly in state OUT.
REQ-024 Arbitration: round-robin; a pointer last holds the most recent winner; the search starts at (last+1) mod N_REQ and wraps; last updates only on a grant.
REQ-025 Fairness: a requester holding req_valid is granted within N_REQ grants.
REQ-026 Arithmetic: the product is unsigned with full 2*W width and no truncation; (2^W-1)^2 gives 0xFFFFFFFE00000001 for W=32.
REQ-027 No requests: when all req_valid are low in IDLE, the state, last and the output register do not change.
REQ-028 Simultaneous release and grant: a result released in OUT by rsp_ready and a new grant in the same cycle are both legal; the old rsp_result is valid in that cycle and the new product appears at T+2.

Reset
REQ-029 When reset is low at a rising edge:
- state goes to IDLE.
- last = N_REQ-1, so requester 0 has top priority first.
- the tag and output registers clear to 0.
- rsp_valid=0, busy=0.
REQ-030 While reset is low, req_ready is 0.
REQ-031 Reset mid-operation: reset in MUL or OUT discards the in-flight operation; no rsp_valid for it ever appears.
REQ-032 After reset is released, the first grant can occur in the first cycle with reset high.

Verification
REQ-033 Single request: requester 2 sends A=3, B=5 in IDLE -> req_ready=0100 in cycle T; rsp_valid at T+2 with rsp_id=2 and rsp_result=15.
REQ-034 Round-robin: all four req_valid held high from reset, rsp_ready tied 1 -> grant order 0,1,2,3,0, with a grant every 2 cycles.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles with requester 1 pending -> rsp_result and rsp_id frozen, req_ready=0; on rsp_ready=1, requester 1 is granted in the same cycle.
REQ-036 Max operands: A=B=0xFFFFFFFF -> rsp_result=0xFFFFFFFE00000001.
REQ-037 Reset in MUL: reset low for 1 cycle during MUL -> rsp_valid stays 0 and busy=0; the next grant goes to requester 0.
REQ-038 Idle stability: no requests for 20 cycles -> busy=0, rsp_valid=0, req_ready=0, and the pointer unchanged (checked by the next grant order).
